// File: rtl/sdpram_read_arbiter.sv
// Two-port read arbiter in front of a simple dual-port RAM.
// Ports: clk/rst_n, req0/rsp0, req1/rsp1 read channels, wr channel, RAM A/B ports.
module sdpram_read_arbiter #(
  parameter int AddrBusWidth = 32,
  parameter int DataBusWidth = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [AddrBusWidth-1:0] req0_addr,
  output logic                    rsp0_valid,
  input  logic                    rsp0_ready,
  output logic [DataBusWidth-1:0] rsp0_data,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [AddrBusWidth-1:0] req1_addr,
  output logic                    rsp1_valid,
  input  logic                    rsp1_ready,
  output logic [DataBusWidth-1:0] rsp1_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [AddrBusWidth-1:0] wr_addr,
  input  logic [DataBusWidth-1:0] wr_data,
  output logic                    mem_we_a,
  output logic [AddrBusWidth-1:0] mem_addr_a,
  output logic [DataBusWidth-1:0] mem_w_data_a,
  output logic                    mem_re_b,
  output logic [AddrBusWidth-1:0] mem_addr_b,
  input  logic [DataBusWidth-1:0] mem_r_data_b
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LIVE  = 2'd1,
    HELD  = 2'd2
  } slot_e;

  slot_e                   r_slot0;
  slot_e                   r_slot1;
  slot_e                   w_slot0_nxt;
  slot_e                   w_slot1_nxt;
  logic                    r_ptr;
  logic [DataBusWidth-1:0] r_hold0;
  logic [DataBusWidth-1:0] r_hold1;
  logic [AddrBusWidth-1:0] r_addr_b;
  logic                    w_elig0;
  logic                    w_elig1;
  logic                    w_ok0;
  logic                    w_ok1;
  logic                    w_iss0;
  logic                    w_iss1;

  function automatic slot_e slot_next(
    input slot_e s,
    input logic  rdy,
    input logic  iss
  );
    unique case (s)
      EMPTY:      slot_next = iss ? LIVE : EMPTY;
      LIVE, HELD: slot_next = rdy ? (iss ? LIVE : EMPTY) : HELD;
      default:    slot_next = EMPTY;
    endcase
  endfunction

  // A port may issue only if its slot frees up on this same edge.
  assign w_elig0 = rst_n & req0_valid
                 & ((r_slot0 == EMPTY) | rsp0_ready);
  assign w_elig1 = rst_n & req1_valid
                 & ((r_slot1 == EMPTY) | rsp1_ready);

  // A same-cycle write to the read address stalls that read.
  assign w_ok0 = w_elig0 & ~(wr_valid & (wr_addr == req0_addr));
  assign w_ok1 = w_elig1 & ~(wr_valid & (wr_addr == req1_addr));

  always_comb begin
    w_iss0 = 1'b0;
    w_iss1 = 1'b0;
    if (r_ptr) begin
      w_iss1 = w_ok1;
      w_iss0 = w_ok0 & ~w_ok1;
    end else begin
      w_iss0 = w_ok0;
      w_iss1 = w_ok1 & ~w_ok0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot0  <= EMPTY;
      r_slot1  <= EMPTY;
      r_ptr    <= 1'b0;
      r_hold0  <= '0;
      r_hold1  <= '0;
      r_addr_b <= '0;
    end else begin
      r_slot0  <= w_slot0_nxt;
      r_slot1  <= w_slot1_nxt;
      r_addr_b <= mem_addr_b;
      // Pointer moves to the port that did not issue.
      if (w_iss0 | w_iss1)
        r_ptr <= w_iss0;
      if ((r_slot0 == LIVE) && !rsp0_ready)
        r_hold0 <= mem_r_data_b;
      if ((r_slot1 == LIVE) && !rsp1_ready)
        r_hold1 <= mem_r_data_b;
    end
  end

  always_comb begin
    w_slot0_nxt = slot_next(r_slot0, rsp0_ready, w_iss0);
    w_slot1_nxt = slot_next(r_slot1, rsp1_ready, w_iss1);
  end

  always_comb begin
    req0_ready   = w_iss0;
    req1_ready   = w_iss1;
    mem_re_b     = w_iss0 | w_iss1;
    mem_addr_b   = w_iss1 ? req1_addr
                 : (w_iss0 ? req0_addr : r_addr_b);
    rsp0_valid   = (r_slot0 != EMPTY);
    rsp1_valid   = (r_slot1 != EMPTY);
    rsp0_data    = (r_slot0 == LIVE) ? mem_r_data_b : r_hold0;
    rsp1_data    = (r_slot1 == LIVE) ? mem_r_data_b : r_hold1;
    wr_ready     = rst_n;
    mem_we_a     = wr_valid & rst_n;
    mem_addr_a   = wr_addr;
    mem_w_data_a = wr_data;
  end

endmodule

// File: tb/tb_sdpram_read_arbiter.sv
// Testbench for sdpram_read_arbiter: RAM model plus queue-based reference.
// Directed scenarios followed by randomized traffic.
module tb_sdpram_read_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_addr;
  logic        rsp0_valid, rsp0_ready;
  logic [31:0] rsp0_data;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_addr;
  logic        rsp1_valid, rsp1_ready;
  logic [31:0] rsp1_data;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_addr, wr_data;
  logic        mem_we_a, mem_re_b;
  logic [31:0] mem_addr_a, mem_w_data_a;
  logic [31:0] mem_addr_b, mem_r_data_b;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] ram    [256];
  logic [31:0] shadow [256];
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          ptr_m;
  int          last_g;

  sdpram_read_arbiter #(
    .AddrBusWidth(32),
    .DataBusWidth(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_addr(req0_addr),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_addr(req1_addr),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_data(rsp1_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_we_a(mem_we_a), .mem_addr_a(mem_addr_a),
    .mem_w_data_a(mem_w_data_a),
    .mem_re_b(mem_re_b), .mem_addr_b(mem_addr_b),
    .mem_r_data_b(mem_r_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first RAM, one cycle read latency.
  always @(posedge clk) begin
    if (mem_re_b) mem_r_data_b <= ram[mem_addr_b[7:0]];
    if (mem_we_a) ram[mem_addr_a[7:0]] <= mem_w_data_a;
  end

  task automatic idle();
    req0_valid = 0; req0_addr = 0;
    req1_valid = 0; req1_addr = 0;
    wr_valid = 0; wr_addr = 0; wr_data = 0;
    rsp0_ready = 1; rsp1_ready = 1;
  endtask

  // One clock of traffic checked against the reference model.
  // Called at a negedge with inputs already applied.
  task automatic cycle();
    logic e0, e1, k0, k1;
    int g;
    #2;
    e0 = req0_valid && (q0.size() == 0 || rsp0_ready);
    e1 = req1_valid && (q1.size() == 0 || rsp1_ready);
    k0 = e0 && !(wr_valid && wr_addr == req0_addr);
    k1 = e1 && !(wr_valid && wr_addr == req1_addr);
    g = -1;
    if (ptr_m == 0) g = k0 ? 0 : (k1 ? 1 : -1);
    else            g = k1 ? 1 : (k0 ? 0 : -1);
    n_chk++;
    if (req0_ready !== (g == 0)) begin
      n_err++;
      $display("FAIL req0_ready got %b exp %b", req0_ready, g == 0);
    end
    n_chk++;
    if (req1_ready !== (g == 1)) begin
      n_err++;
      $display("FAIL req1_ready got %b exp %b", req1_ready, g == 1);
    end
    n_chk++;
    if (mem_re_b !== (g >= 0)) begin
      n_err++;
      $display("FAIL mem_re_b got %b exp %b", mem_re_b, g >= 0);
    end
    if (g >= 0) begin
      n_chk++;
      if (mem_addr_b !== (g == 0 ? req0_addr : req1_addr)) begin
        n_err++;
        $display("FAIL mem_addr_b got %h exp %h", mem_addr_b,
                 g == 0 ? req0_addr : req1_addr);
      end
    end
    n_chk++;
    if (mem_we_a !== wr_valid) begin
      n_err++;
      $display("FAIL mem_we_a got %b exp %b", mem_we_a, wr_valid);
    end
    if (wr_valid) begin
      n_chk++;
      if (mem_addr_a !== wr_addr || mem_w_data_a !== wr_data) begin
        n_err++;
        $display("FAIL mem_a got %h/%h exp %h/%h", mem_addr_a,
                 mem_w_data_a, wr_addr, wr_data);
      end
    end
    n_chk++;
    if (rsp0_valid !== (q0.size() != 0)) begin
      n_err++;
      $display("FAIL rsp0_valid got %b exp %b", rsp0_valid, q0.size() != 0);
    end else if (q0.size() != 0) begin
      n_chk++;
      if (rsp0_data !== q0[0]) begin
        n_err++;
        $display("FAIL rsp0_data got %h exp %h", rsp0_data, q0[0]);
      end
    end
    n_chk++;
    if (rsp1_valid !== (q1.size() != 0)) begin
      n_err++;
      $display("FAIL rsp1_valid got %b exp %b", rsp1_valid, q1.size() != 0);
    end else if (q1.size() != 0) begin
      n_chk++;
      if (rsp1_data !== q1[0]) begin
        n_err++;
        $display("FAIL rsp1_data got %h exp %h", rsp1_data, q1[0]);
      end
    end
    @(posedge clk);
    if (q0.size() != 0 && rsp0_ready) void'(q0.pop_front());
    if (q1.size() != 0 && rsp1_ready) void'(q1.pop_front());
    if (g == 0) q0.push_back(shadow[req0_addr[7:0]]);
    if (g == 1) q1.push_back(shadow[req1_addr[7:0]]);
    if (g >= 0) ptr_m = 1 - g;
    if (wr_valid) shadow[wr_addr[7:0]] = wr_data;
    last_g = g;
    @(negedge clk);
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    ptr_m = 0;
    last_g = -1;
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1;
  endtask

  task automatic drain();
    idle();
    repeat (2) cycle();
  endtask

  task automatic test_reset();
    idle();
    req0_valid = 1; req1_valid = 1; req1_addr = 1;
    wr_valid = 1; wr_addr = 7;
    rst_n = 0;
    #2;
    n_chk++;
    if ({req0_ready, req1_ready, wr_ready, mem_we_a, mem_re_b,
         rsp0_valid, rsp1_valid} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_outs got %b exp 0000000",
               {req0_ready, req1_ready, wr_ready, mem_we_a,
                mem_re_b, rsp0_valid, rsp1_valid});
    end
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (rsp0_data !== 32'h0 || rsp1_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_hold got %h/%h exp 0/0", rsp0_data, rsp1_data);
    end
    apply_reset();
  endtask

  task automatic test_preload();
    idle();
    for (int i = 0; i < 32; i++) begin
      wr_valid = 1;
      wr_addr = i;
      wr_data = $urandom;
      #1;
      n_chk++;
      if (wr_ready !== 1'b1) begin
        n_err++;
        $display("FAIL wr_ready got %b exp 1", wr_ready);
      end
      cycle();
    end
    idle();
  endtask

  task automatic test_single_read();
    drain();
    wr_valid = 1; wr_addr = 32'h10; wr_data = 32'hDEADBEEF;
    cycle();
    idle();
    req0_valid = 1; req0_addr = 32'h10;
    #1;
    n_chk++;
    if (req0_ready !== 1'b1) begin
      n_err++;
      $display("FAIL single_req got %b exp 1", req0_ready);
    end
    cycle();
    req0_valid = 0;
    #1;
    n_chk++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL single_rsp got %b/%h exp 1/deadbeef",
               rsp0_valid, rsp0_data);
    end
    cycle();
    #1;
    n_chk++;
    if (rsp0_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_end got %b exp 0", rsp0_valid);
    end
    cycle();
  endtask

  task automatic test_round_robin();
    int a0, a1;
    apply_reset();
    a0 = 0; a1 = 1;
    for (int k = 0; k < 10; k++) begin
      req0_valid = 1; req0_addr = a0;
      req1_valid = 1; req1_addr = a1;
      #1;
      n_chk++;
      if (req0_ready !== (k % 2 == 0)) begin
        n_err++;
        $display("FAIL rr_order[%0d] got %b exp %b", k, req0_ready,
                 k % 2 == 0);
      end
      if (k > 0) begin
        n_chk++;
        if ((rsp0_valid ^ rsp1_valid) !== 1'b1) begin
          n_err++;
          $display("FAIL rr_rsp[%0d] got %b%b exp one", k,
                   rsp0_valid, rsp1_valid);
        end
      end
      cycle();
      if (last_g == 0) a0 = a0 + 2;
      if (last_g == 1) a1 = a1 + 2;
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] exp0;
    drain();
    req0_valid = 1; req0_addr = 5;
    exp0 = shadow[5];
    cycle();
    req0_addr = 6;
    req1_valid = 1; req1_addr = 3;
    rsp0_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
        n_err++;
        $display("FAIL bp_grant[%0d] got %b%b exp 01", k,
                 req0_ready, req1_ready);
      end
      n_chk++;
      if (rsp0_data !== exp0) begin
        n_err++;
        $display("FAIL bp_data[%0d] got %h exp %h", k, rsp0_data, exp0);
      end
      cycle();
    end
    rsp0_ready = 1;
    #1;
    n_chk++;
    if (req0_ready !== 1'b1 || rsp0_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release got %b%b exp 11", req0_ready, rsp0_valid);
    end
    cycle();
    drain();
  endtask

  task automatic test_hazard();
    drain();
    wr_valid = 1; wr_addr = 32'h20; wr_data = 32'h55;
    req1_valid = 1; req1_addr = 32'h20;
    #1;
    n_chk++;
    if (req1_ready !== 1'b0 || mem_we_a !== 1'b1) begin
      n_err++;
      $display("FAIL hz_stall got %b/%b exp 0/1", req1_ready, mem_we_a);
    end
    cycle();
    wr_valid = 0;
    #1;
    n_chk++;
    if (req1_ready !== 1'b1) begin
      n_err++;
      $display("FAIL hz_issue got %b exp 1", req1_ready);
    end
    cycle();
    req1_valid = 0;
    #1;
    n_chk++;
    if (rsp1_valid !== 1'b1 || rsp1_data !== 32'h55) begin
      n_err++;
      $display("FAIL hz_data got %b/%h exp 1/00000055",
               rsp1_valid, rsp1_data);
    end
    cycle();
  endtask

  task automatic test_reset_midflight();
    drain();
    req1_valid = 1; req1_addr = 9; rsp1_ready = 0;
    cycle();
    req1_valid = 0;
    #1;
    n_chk++;
    if (rsp1_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mf_live got %b exp 1", rsp1_valid);
    end
    rst_n = 0;
    #1;
    n_chk++;
    if (rsp1_valid !== 1'b0 || wr_ready !== 1'b0) begin
      n_err++;
      $display("FAIL mf_async got %b/%b exp 0/0", rsp1_valid, wr_ready);
    end
    @(negedge clk);
    @(negedge clk);
    model_reset();
    idle();
    rst_n = 1;
    req0_valid = 1; req0_addr = 11;
    req1_valid = 1; req1_addr = 12;
    #1;
    n_chk++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mf_norsp got %b%b exp 00", rsp0_valid, rsp1_valid);
    end
    n_chk++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL mf_first got %b%b exp 10", req0_ready, req1_ready);
    end
    cycle();
    req0_valid = 0;
    cycle();
    drain();
  endtask

  task automatic test_random();
    idle();
    for (int k = 0; k < 600; k++) begin
      if (!(req0_valid && last_g != 0)) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_addr = $urandom_range(0, 31);
      end
      if (!(req1_valid && last_g != 1)) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_addr = $urandom_range(0, 31);
      end
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_addr = $urandom_range(0, 31);
      wr_data = $urandom;
      cycle();
    end
    drain();
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 0;
    @(negedge clk);
    test_reset();
    test_preload();
    test_single_read();
    test_round_robin();
    test_backpressure();
    test_hazard();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
